// File: rtl/fp_pkg.sv
// Shared FP32 definitions: field widths, bias, FSM encoding and field-slice helpers.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int SIG_W   = MAN_W + 1;   // significand including hidden bit
  localparam int PROD_W  = 2 * SIG_W;   // full significand product width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fp32_mul_seq_mant.sv
// 24x24 shift-add significand multiplier: one partial product per clock, 24 clocks per product.
module fp32_mant_mul_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIG_W-1:0]  ma,
  input  logic [SIG_W-1:0]  mb,
  output logic              done,
  output logic [PROD_W-1:0] prod
);

  logic [SIG_W-1:0]  ma_q, ma_d;
  logic [SIG_W-1:0]  mb_q, mb_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // Next-state: load on start, otherwise add one shifted partial product per busy cycle.
  always_comb begin
    ma_d   = ma_q;
    mb_d   = mb_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      ma_d   = ma;
      mb_d   = mb;
      acc_d  = '0;
      cnt_d  = 5'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (mb_q[cnt_q]) begin
        acc_d = acc_q + ({{(PROD_W-SIG_W){1'b0}}, ma_q} << cnt_q);
      end else begin
        acc_d = acc_q;
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd23) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers; reset abandons any product in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_q   <= '0;
      mb_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
    end else begin
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the cycle whose edge performs the last iteration, so prod is final right after it.
  assign done = busy_q && (cnt_q == 5'd23);
  assign prod = acc_q;

endmodule

// File: rtl/fp32_mul_seq.sv
// Iterative FP32 multiplier: handshake FSM, sign/exponent path, normalisation and flags.
module fp32_mul_seq
  import fp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow
);

  fsm_state_e        state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  ea_q, ea_d;
  logic [EXP_W-1:0]  eb_q, eb_d;
  logic              zflag_q, zflag_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              accept_s;
  logic              mul_done_s;
  logic [PROD_W-1:0] prod_s;
  logic signed [9:0] exp_s;
  logic signed [9:0] exp_adj_s;
  logic [MAN_W-1:0]  man_s;

  assign accept_s = in_valid && (state_q == ST_IDLE);

  fp32_mant_mul_seq u_mant (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept_s),
    .ma    ({1'b1, fp_man(a)}),
    .mb    ({1'b1, fp_man(b)}),
    .done  (mul_done_s),
    .prod  (prod_s)
  );

  // Exponent sum in 10-bit signed plus one-bit normalisation of the significand product.
  always_comb begin
    exp_s = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
    if (prod_s[PROD_W-1]) begin
      exp_adj_s = exp_s + 10'sd1;
      man_s     = prod_s[46:24];
    end else begin
      exp_adj_s = exp_s;
      man_s     = prod_s[45:23];
    end
  end

  // Handshake FSM next state plus operand capture and result/flag formation.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    zflag_d     = zflag_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          sign_d  = fp_sign(a) ^ fp_sign(b);
          ea_d    = fp_exp(a);
          eb_d    = fp_exp(b);
          zflag_d = (fp_exp(a) == 8'd0) || (fp_exp(b) == 8'd0);
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d = ST_NORM;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_NORM: begin
        // Zero operands win over any exponent range result.
        if (zflag_q) begin
          result_d    = {sign_q, 31'd0};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else if (exp_adj_s >= 10'sd255) begin
          result_d    = {sign_q, 8'hFF, 23'd0};
          overflow_d  = 1'b1;
          underflow_d = 1'b0;
        end else if (exp_adj_s <= 10'sd0) begin
          result_d    = {sign_q, 31'd0};
          overflow_d  = 1'b0;
          underflow_d = 1'b1;
        end else begin
          result_d    = {sign_q, exp_adj_s[7:0], man_s};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Flags are only meaningful alongside out_valid, so drop them on handoff.
        if (out_ready) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      zflag_q     <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      zflag_q     <= zflag_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: directed cases, handshake/reset scenarios, random ops.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fp32_mul_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, underflow, result} from the arithmetic rules with a plain integer multiply.
  function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    longint      p;
    int          e;
    logic [22:0] m;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {2'b00, s, 31'd0};
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p >= (64'sd1 <<< 47)) begin
      e = e + 1;
      m = 23'((p >> 24) & 64'h7F_FFFF);
    end else begin
      m = 23'((p >> 23) & 64'h7F_FFFF);
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, 8'(e), m};
  endfunction

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    chk("latency", n, 32'd25);
  endtask

  task automatic check_out(input string tag, input logic [33:0] exp);
    chk({tag, "_res"}, result, exp[31:0]);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp[33]});
    chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, exp[32]});
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("back_ready", {31'd0, in_ready}, 32'd1);
    chk("flags_clr", {30'd0, overflow, underflow}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [33:0] exp);
    issue(aa, bb);
    wait_done();
    check_out(tag, exp);
    consume();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived expectations.
    run_op("mul2x3",  32'h40000000, 32'h40400000, {2'b00, 32'h40C00000});
    run_op("mul1p5",  32'h3FC00000, 32'h3FC00000, {2'b00, 32'h40100000});
    run_op("neg",     32'hC0000000, 32'h3F000000, {2'b00, 32'hBF800000});
    run_op("ovf",     32'h7F000000, 32'h7F000000, {2'b10, 32'h7F800000});
    run_op("unf",     32'h00800000, 32'h00800000, {2'b01, 32'h00000000});
    run_op("zero",    32'h80000000, 32'h40490FDB, {2'b00, 32'h80000000});

    // Back-pressure in DONE, then an immediately held follow-on request.
    issue(32'h40000000, 32'h40400000);
    wait_done();
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'h3FC00000;
    b = 32'h3FC00000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handoff_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held_accept", {31'd0, in_ready}, 32'd0);
    wait_done();
    check_out("held", {2'b00, 32'h40100000});
    consume();

    // Reset in the middle of the multiply.
    issue(32'h40000000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'h40000000, 32'h40400000, {2'b00, 32'h40C00000});

    // Randomised operands: mostly normals across the whole exponent range, some zeros.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 9) == 0) ra[30:23] = 8'd0;
      else if (ra[30:23] == 8'hFF) ra[30:23] = 8'hFE;
      if ($urandom_range(0, 9) == 0) rb[30:23] = 8'd0;
      else if (rb[30:23] == 8'hFF) rb[30:23] = 8'h7F;
      if (k % 3 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      if (rb[30:23] != 8'd0 && rb[30:23] == 8'd0) rb = 32'd0;
      run_op("rand", ra, rb, ref_mul(ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
